// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: PC enable plus IF/ID and ID/EXE stall/flush from branch, load-use and halt.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W        = 4,
  parameter int FLUSH_CYCLES      = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_taken,
  input  logic                  exe_rd_mem_en,
  input  logic                  exe_wb_en,
  input  logic [REG_ADDR_W-1:0] exe_dst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [REG_ADDR_W-1:0] id_src3,
  input  logic [2:0]            id_src_used,
  input  logic                  halt_req,
  output logic                  halt_ack,
  output logic                  pc_en,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idexe_flush,
  output logic [1:0]            ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int MAX_CYC = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;
  localparam logic [CW-1:0] STALL_LOAD = (LOAD_STALL_CYCLES > 1) ? CW'(LOAD_STALL_CYCLES - 2) : '0;

  if (FLUSH_CYCLES < 1 || LOAD_STALL_CYCLES < 1 || CNT_W < 1 || REG_ADDR_W < 1) begin : g_param_check
    $error("pipeline_hazard_ctrl: cycle counts, CNT_W and REG_ADDR_W must all be >= 1");
  end

  state_t        state, state_nx, eff_state;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    src_hit;
  logic          luh;
  logic          stall_req;

  assign src_hit = {id_src3 == exe_dst, id_src2 == exe_dst, id_src1 == exe_dst} & id_src_used;
  assign luh     = exe_rd_mem_en & exe_wb_en & (|src_hit);

  // Dropping halt_req resumes RUN behaviour in the same cycle, before the state register follows.
  assign eff_state = (state == HALT && !halt_req) ? RUN : state;

  always_comb begin
    pc_en       = 1'b1;
    stall_req   = 1'b0;
    ifid_flush  = 1'b0;
    idexe_flush = 1'b0;
    state_nx    = eff_state;
    cnt_nx      = cnt;
    if (rst) begin
      case (eff_state)
        RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nx = FLUSH;
              cnt_nx   = FLUSH_LOAD;
            end
          end else if (luh) begin
            pc_en       = 1'b0;
            stall_req   = 1'b1;
            idexe_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nx = STALL;
              cnt_nx   = STALL_LOAD;
            end
          end else if (halt_req) begin
            pc_en       = 1'b0;
            stall_req   = 1'b1;
            idexe_flush = 1'b1;
            state_nx    = HALT;
          end
        end
        STALL: begin
          // EXE holds a bubble here, so a branch_taken cannot be genuine and is ignored.
          pc_en       = 1'b0;
          stall_req   = 1'b1;
          idexe_flush = 1'b1;
          if (cnt == '0) state_nx = RUN;
          else           cnt_nx   = cnt - 1'b1;
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idexe_flush = 1'b1;
          if (branch_taken)   cnt_nx   = FLUSH_LOAD;
          else if (cnt == '0) state_nx = RUN;
          else                cnt_nx   = cnt - 1'b1;
        end
        HALT: begin
          idexe_flush = 1'b1;
          if (branch_taken) begin
            ifid_flush = 1'b1;
          end else begin
            pc_en     = 1'b0;
            stall_req = 1'b1;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign ifid_stall = stall_req & ~ifid_flush;
  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      cnt      <= '0;
      halt_ack <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      halt_ack <= (state_nx == HALT);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1)     stall_cycles <= stall_cycles + 1'b1;
      if (ifid_flush && flush_cycles != '1) flush_cycles <= flush_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the IF → IF/ID → ID → ID/EXE → EXE pipeline. It drives the PC enable and the pipe-register stall and flush controls from three sources: the EXE-stage branch outcome, load-use hazards between the ID and EXE stages, and an external halt request. It replaces the constant `pc_en`/`stop` ties at the top level with a registered state machine plus same-cycle hazard decode.

## Interface
Parameters:
- REG_ADDR_W, 4, register-file address width
- FLUSH_CYCLES, 2, cycles `ifid_flush` is held after a taken branch (≥1)
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (≥1)
- CNT_W, 16, width of the performance counters (macro-gated)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- branch_taken  in  1  EXE resolved a taken branch this cycle
- exe_rd_mem_en  in  1  instruction in EXE is a load
- exe_wb_en  in  1  instruction in EXE writes the register file
- exe_dst  in  REG_ADDR_W  destination register of the EXE instruction
- id_src1 / id_src2 / id_src3  in  REG_ADDR_W  source registers of the ID instruction
- id_src_used  in  3  per-source valid bits; bit0 = src1
- halt_req  in  1  external request to freeze fetch
- halt_ack  out  1  pipeline frozen and drained of new issue
- pc_en  out  1  PC update enable
- ifid_stall  out  1  hold the IF/ID register
- ifid_flush  out  1  load NOP into IF/ID
- idexe_flush  out  1  load bubble (all enables 0) into ID/EXE
- ctrl_state  out  2  current state (RUN=0, STALL=1, FLUSH=2, HALT=3)
- stall_cycles / flush_cycles  out  CNT_W  performance counters (only with macro)

## Operation
- Outputs are combinational functions of the registered state, the registered down-counter `cnt`, and the current inputs. `halt_ack` is registered.
- luh (load-use hazard) = exe_rd_mem_en & exe_wb_en & OR over i of (id_src_used[i] & id_srci == exe_dst).
- Priority within a cycle: branch_taken > luh > halt_req.
- RUN:
  - Default outputs: pc_en=1, others 0.
  - On branch_taken: ifid_flush=1, idexe_flush=1, pc_en=1 (target loads). If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - Else on luh: pc_en=0, ifid_stall=1, idexe_flush=1. If LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-2.
  - Else on halt_req: pc_en=0, ifid_stall=1, idexe_flush=1; go to HALT.
- STALL: pc_en=0, ifid_stall=1, idexe_flush=1. branch_taken is ignored (EXE holds a bubble). When cnt==0, go to RUN; otherwise decrement cnt.
- FLUSH: pc_en=1, ifid_flush=1, idexe_flush=1. When cnt==0, go to RUN; otherwise decrement cnt. A new branch_taken reloads cnt=FLUSH_CYCLES-2.
- HALT:
  - While halt_req=1: pc_en=0, ifid_stall=1, idexe_flush=1, halt_ack=1 from the second HALT cycle onward.
  - branch_taken in HALT (an in-flight EXE instruction): pc_en=1 and ifid_flush=1 for that cycle; remain in HALT.
  - When halt_req drops: return to RUN and evaluate outputs as RUN in the same cycle. halt_ack clears on the next edge.
- ifid_stall and ifid_flush are never both 1; flush wins, and ifid_stall is forced to 0 whenever ifid_flush=1.

## Timing
- Reset (rst=0, async): ctrl_state=RUN, cnt=0, halt_ack=0, counters=0. Outputs during reset: pc_en=1, ifid_stall=0, ifid_flush=0, idexe_flush=0. Reset mid-STALL, FLUSH or HALT aborts immediately.
- Hazard response latency is 0 cycles, combinational with the causing input.
- Taken branch: IF/ID is flushed for exactly FLUSH_CYCLES cycles. ID/EXE is flushed for the same window.
- Load-use: exactly LOAD_STALL_CYCLES cycles with pc_en=0.
- halt_ack rises 1 cycle after HALT entry and falls 1 cycle after halt_req deasserts.
- cnt is $clog2 of the larger cycle parameter wide and never wraps: decrements stop at 0.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_en=0.
  - flush_cycles increments on every cycle with ifid_flush=1.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- HAZARD_PERF_CNT_EN undefined: both counter ports are absent and no counter logic is synthesized.

## Test plan
- Reset release with all inputs 0 → pc_en=1, all stall/flush outputs 0, ctrl_state=0, halt_ack=0.
- exe_rd_mem_en=1, exe_wb_en=1, exe_dst=5, id_src2=5, id_src_used=3'b010, LOAD_STALL_CYCLES=1 → exactly 1 cycle of pc_en=0, ifid_stall=1, idexe_flush=1, then RUN. The same case with id_src_used=3'b001 → no stall.
- branch_taken pulse for 1 cycle, FLUSH_CYCLES=2 → ifid_flush=1 and idexe_flush=1 for 2 cycles, pc_en=1 throughout, then RUN.
- branch_taken and luh in the same cycle → flush behaviour only, with pc_en=1 and ifid_stall=0.
- halt_req held for 5 cycles → pc_en=0 for 5 cycles, halt_ack high for cycles 2–5 plus 1 trailing cycle. A branch_taken in HALT cycle 1 → pc_en=1 and ifid_flush=1 for that cycle only.
- With HAZARD_PERF_CNT_EN: after scenarios 2 and 3, stall_cycles=1 and flush_cycles=2. Asserting rst mid-FLUSH → counters and state return to 0 asynchronously.
